// File: rtl/iram_arb_pkg.sv
// Shared types and constants for the InstructionRam b-port arbiter.
// Build option: IRAM_ARB_ROUND_ROBIN_EN (see iram_arb_grant2).
package iram_arb_pkg;

   // Access sequencer states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2
   } arb_state_e;

   // Requester identifiers
   localparam logic REQ_DBG = 1'b0;   // debug module
   localparam logic REQ_LDR = 1'b1;   // program loader / SMC store path

   // Upper address bits that must be zero for a legal access
   localparam int unsigned ADDR_VALID_MSB = 31;
   localparam int unsigned ADDR_VALID_LSB = 18;

endpackage

// File: rtl/iram_arb_grant2.sv
// Two-way combinational grant with a last-grant register.
// Build option: IRAM_ARB_ROUND_ROBIN_EN selects round-robin on a tie;
// without it requester 0 (debug) always wins a tie.
module iram_arb_grant2
   import iram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   input  logic       accept_i,
   output logic       gnt_any_o,
   output logic       gnt_id_o
);

   assign gnt_any_o = |req_i;

`ifdef IRAM_ARB_ROUND_ROBIN_EN
   logic last_grant_q;

   // Remember the winner of every accepted request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= REQ_LDR;
      end else if (accept_i) begin
         last_grant_q <= gnt_id_o;
      end
   end

   // Tie goes to the requester that did not win last time
   always_comb begin
      gnt_id_o = REQ_DBG;
      if (req_i == 2'b11) begin
         gnt_id_o = ~last_grant_q;
      end else if (req_i[1]) begin
         gnt_id_o = REQ_LDR;
      end
   end
`else
   // Fixed priority needs no history
   logic unused_fixed_prio;
   assign unused_fixed_prio = ^{clk, rst_n, accept_i};

   // Debug requester always wins a tie
   always_comb begin
      gnt_id_o = req_i[0] ? REQ_DBG : REQ_LDR;
   end
`endif

endmodule

// File: rtl/iram_portb_arbiter.sv
// Shares the InstructionRam b port between the debug module (req0) and the
// program loader / SMC store path (req1). Each access runs IDLE -> ISSUE ->
// CAPTURE and responds on a one-cycle strobe the cycle after CAPTURE.
// Build option: IRAM_ARB_ROUND_ROBIN_EN (round-robin tie break, else fixed).
module iram_portb_arbiter
   import iram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W        = 32,
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned VALID_HI_BITS = ADDR_VALID_MSB - ADDR_VALID_LSB + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   output logic              rsp0_err,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              rsp1_err,
   output logic              ram_web,
   output logic [ADDR_W-1:0] ram_addrb,
   output logic [DATA_W-1:0] ram_dinb,
   input  logic [DATA_W-1:0] ram_doutb,
   output logic              busy
);

   arb_state_e        state_q;
   logic              we_q;
   logic              err_q;
   logic              gnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [1:0]        rsp_valid_q;
   logic [DATA_W-1:0] rsp_rdata_q [2];
   logic [1:0]        rsp_err_q;

   logic              idle;
   logic              gnt_any;
   logic              gnt_id;
   logic              accept;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_err;

   assign idle = (state_q == ST_IDLE);

   iram_arb_grant2 u_grant (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     ({req1_valid, req0_valid}),
      .accept_i  (accept),
      .gnt_any_o (gnt_any),
      .gnt_id_o  (gnt_id)
   );

   assign req0_ready = idle & gnt_any & (gnt_id == REQ_DBG);
   assign req1_ready = idle & gnt_any & (gnt_id == REQ_LDR);
   assign accept     = idle & gnt_any;

   // Steer the winning requester's fields into the request registers
   always_comb begin
      sel_we    = req0_we;
      sel_addr  = req0_addr;
      sel_wdata = req0_wdata;
      if (gnt_id == REQ_LDR) begin
         sel_we    = req1_we;
         sel_addr  = req1_addr;
         sel_wdata = req1_wdata;
      end
      sel_err = (sel_addr[ADDR_W-1 -: VALID_HI_BITS] != '0);
   end

   // Access sequencer: accept, issue to RAM, capture and respond
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         we_q           <= 1'b0;
         err_q          <= 1'b0;
         gnt_q          <= REQ_DBG;
         addr_q         <= '0;
         wdata_q        <= '0;
         rsp_valid_q    <= '0;
         rsp_rdata_q[0] <= '0;
         rsp_rdata_q[1] <= '0;
         rsp_err_q      <= '0;
      end else begin
         rsp_valid_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  we_q    <= sel_we;
                  err_q   <= sel_err;
                  gnt_q   <= gnt_id;
                  addr_q  <= sel_addr;
                  wdata_q <= sel_wdata;
                  state_q <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               state_q <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               rsp_valid_q[gnt_q] <= 1'b1;
               rsp_rdata_q[gnt_q] <= err_q ? '0 : ram_doutb;
               rsp_err_q[gnt_q]   <= err_q;
               state_q            <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // RAM strobe exists only in ISSUE; address/data are held from the request
   assign ram_web   = (state_q == ST_ISSUE) & we_q & ~err_q;
   assign ram_addrb = addr_q;
   assign ram_dinb  = wdata_q;
   assign busy      = ~idle;

   assign rsp0_valid = rsp_valid_q[0];
   assign rsp0_rdata = rsp_rdata_q[0];
   assign rsp0_err   = rsp_err_q[0];
   assign rsp1_valid = rsp_valid_q[1];
   assign rsp1_rdata = rsp_rdata_q[1];
   assign rsp1_err   = rsp_err_q[1];

endmodule

// File: tb/tb_iram_portb_arbiter.sv
// Self-checking bench for iram_portb_arbiter with a small behavioural
// InstructionRam b port and a transaction-level reference model.
// Honours IRAM_ARB_ROUND_ROBIN_EN for tie-break expectations.
module tb_iram_portb_arbiter;

   logic        clk;
   logic        rst_n;
   logic        req0_valid, req0_ready, req0_we;
   logic [31:0] req0_addr, req0_wdata;
   logic        rsp0_valid, rsp0_err;
   logic [31:0] rsp0_rdata;
   logic        req1_valid, req1_ready, req1_we;
   logic [31:0] req1_addr, req1_wdata;
   logic        rsp1_valid, rsp1_err;
   logic [31:0] rsp1_rdata;
   logic        ram_web;
   logic [31:0] ram_addrb, ram_dinb, ram_doutb;
   logic        busy;

   int          vectors;
   int          miscompares;
   int          web_pulses;
   logic        mem_init;
   logic [31:0] ram_mem [64];
   logic [31:0] exp_mem [64];
   logic        model_last;
   logic [31:0] last_rd  [2];
   logic        last_err [2];

   iram_portb_arbiter #(
      .ADDR_W        (32),
      .DATA_W        (32),
      .VALID_HI_BITS (14)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_we    (req0_we),
      .req0_addr  (req0_addr),
      .req0_wdata (req0_wdata),
      .rsp0_valid (rsp0_valid),
      .rsp0_rdata (rsp0_rdata),
      .rsp0_err   (rsp0_err),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_we    (req1_we),
      .req1_addr  (req1_addr),
      .req1_wdata (req1_wdata),
      .rsp1_valid (rsp1_valid),
      .rsp1_rdata (rsp1_rdata),
      .rsp1_err   (rsp1_err),
      .ram_web    (ram_web),
      .ram_addrb  (ram_addrb),
      .ram_dinb   (ram_dinb),
      .ram_doutb  (ram_doutb),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input int i);
      logic [31:0] v;
      if (i == 4) return 32'hDEADBEEF;
      if (i == 8) return 32'hAAAA5555;
      v = 32'(i) * 32'h9E3779B9;
      return v ^ 32'h0F0F1234;
   endfunction

   // Behavioural RAM: 1-cycle synchronous read, read-before-write
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) ram_mem[i] <= pat(i);
         ram_doutb <= '0;
      end else begin
         ram_doutb <= ram_mem[ram_addrb[7:2]];
         if (ram_web) ram_mem[ram_addrb[7:2]] <= ram_dinb;
      end
   end

   always @(posedge clk) begin
      if (mem_init) web_pulses <= 0;
      else if (ram_web) web_pulses <= web_pulses + 1;
   end

   function automatic logic in_range(input logic [31:0] a);
      return a < 32'h0004_0000;
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a / 4) % 64);
   endfunction

   function automatic logic rdy(input int r);
      return (r == 0) ? req0_ready : req1_ready;
   endfunction
   function automatic logic rv(input int r);
      return (r == 0) ? rsp0_valid : rsp1_valid;
   endfunction
   function automatic logic [31:0] rdat(input int r);
      return (r == 0) ? rsp0_rdata : rsp1_rdata;
   endfunction
   function automatic logic rerr(input int r);
      return (r == 0) ? rsp0_err : rsp1_err;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int r, input logic v, input logic we,
                        input logic [31:0] a, input logic [31:0] wd);
      if (r == 0) begin
         req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = wd;
      end else begin
         req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = wd;
      end
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 16383)) << 18);
      return a;
   endfunction

   task automatic chk_hold(input string tag);
      chk({tag, "/hold_rd0"}, rsp0_rdata, last_rd[0]);
      chk({tag, "/hold_rd1"}, rsp1_rdata, last_rd[1]);
      chk1({tag, "/hold_err0"}, rsp0_err, last_err[0]);
      chk1({tag, "/hold_err1"}, rsp1_err, last_err[1]);
   endtask

   // One isolated access from requester r, starting in IDLE
   task automatic txn(input int r, input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input string tag);
      logic        ok;
      logic        wr;
      logic [31:0] erd;
      int          w0;
      int          o;
      o   = 1 - r;
      ok  = in_range(a);
      wr  = we && ok;
      erd = ok ? exp_mem[widx(a)] : 32'h0;
      w0  = web_pulses;
      drive(r, 1'b1, we, a, wd);
      #1;
      chk1({tag, "/ready"}, rdy(r), 1'b1);
      chk1({tag, "/other_ready"}, rdy(o), 1'b0);
      chk1({tag, "/web_N"}, ram_web, 1'b0);
      model_last = (r == 1);
      tick;
      drive(r, 1'b0, we, a, wd);
      chk1({tag, "/busy_N1"}, busy, 1'b1);
      chk1({tag, "/web_N1"}, ram_web, wr);
      chk({tag, "/addrb"}, ram_addrb, a);
      chk({tag, "/dinb"}, ram_dinb, wd);
      tick;
      chk1({tag, "/web_N2"}, ram_web, 1'b0);
      chk1({tag, "/rsp_early"}, rv(r), 1'b0);
      tick;
      chk1({tag, "/rsp_valid"}, rv(r), 1'b1);
      chk1({tag, "/other_rsp"}, rv(o), 1'b0);
      chk({tag, "/rdata"}, rdat(r), erd);
      chk1({tag, "/err"}, rerr(r), !ok);
      chk1({tag, "/busy_N3"}, busy, 1'b0);
      chk({tag, "/web_count"}, 32'(web_pulses - w0), wr ? 32'd1 : 32'd0);
      if (wr) exp_mem[widx(a)] = wd;
      last_rd[r]  = erd;
      last_err[r] = !ok;
      tick;
      chk1({tag, "/rsp_one_cycle"}, rv(r), 1'b0);
      chk_hold(tag);
   endtask

   // Requesters hold reads continuously; checks who wins each accept
   task automatic contend(input logic v0, input logic v1, input int n, input string tag);
      logic [31:0] a [2];
      int          w;
      logic [31:0] erd;
      logic        eerr;
      a[0] = rand_addr();
      a[1] = rand_addr();
      drive(0, v0, 1'b0, a[0], 32'h0);
      drive(1, v1, 1'b0, a[1], 32'h0);
      #1;
      for (int k = 0; k < n; k++) begin
         if (v0 && v1) begin
`ifdef IRAM_ARB_ROUND_ROBIN_EN
            w = model_last ? 0 : 1;
`else
            w = 0;
`endif
         end else begin
            w = v0 ? 0 : 1;
         end
         chk1({tag, "/ready0"}, req0_ready, w == 0);
         chk1({tag, "/ready1"}, req1_ready, w == 1);
         chk1({tag, "/busy_acc"}, busy, 1'b0);
         model_last = (w == 1);
         eerr = !in_range(a[w]);
         erd  = eerr ? 32'h0 : exp_mem[widx(a[w])];
         tick;
         chk1({tag, "/ready0_off"}, req0_ready, 1'b0);
         chk1({tag, "/ready1_off"}, req1_ready, 1'b0);
         chk1({tag, "/busy_mid"}, busy, 1'b1);
         chk1({tag, "/web_rd"}, ram_web, 1'b0);
         a[w] = rand_addr();
         drive(w, 1'b1, 1'b0, a[w], 32'h0);
         tick;
         chk1({tag, "/busy_cap"}, busy, 1'b1);
         tick;
         chk1({tag, "/rsp_win"}, rv(w), 1'b1);
         chk1({tag, "/rsp_lose"}, rv(1 - w), 1'b0);
         chk({tag, "/rdata"}, rdat(w), erd);
         chk1({tag, "/err"}, rerr(w), eerr);
         last_rd[w]  = erd;
         last_err[w] = eerr;
         if (k == n - 1) begin
            drive(0, 1'b0, 1'b0, a[0], 32'h0);
            drive(1, 1'b0, 1'b0, a[1], 32'h0);
         end
         #1;
      end
      tick;
      chk1({tag, "/end_rsp0"}, rsp0_valid, 1'b0);
      chk1({tag, "/end_rsp1"}, rsp1_valid, 1'b0);
      chk1({tag, "/end_busy"}, busy, 1'b0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      model_last  = 1'b1;
      last_rd[0]  = '0;  last_rd[1]  = '0;
      last_err[0] = 1'b0; last_err[1] = 1'b0;
      for (int i = 0; i < 64; i++) exp_mem[i] = pat(i);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      mem_init = 1'b1;
      rst_n    = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      chk1("rst/ready0", req0_ready, 1'b0);
      chk1("rst/ready1", req1_ready, 1'b0);
      chk1("rst/rsp0_valid", rsp0_valid, 1'b0);
      chk1("rst/rsp1_valid", rsp1_valid, 1'b0);
      chk("rst/rsp0_rdata", rsp0_rdata, 32'h0);
      chk("rst/rsp1_rdata", rsp1_rdata, 32'h0);
      chk1("rst/rsp0_err", rsp0_err, 1'b0);
      chk1("rst/rsp1_err", rsp1_err, 1'b0);
      chk1("rst/web", ram_web, 1'b0);
      chk("rst/addrb", ram_addrb, 32'h0);
      chk("rst/dinb", ram_dinb, 32'h0);
      chk1("rst/busy", busy, 1'b0);

      mem_init = 1'b0;
      rst_n    = 1'b1;
      tick;

      // Directed accesses
      txn(0, 1'b0, 32'h0000_0010, 32'h0, "rd_w4");
      txn(1, 1'b1, 32'h0000_0020, 32'h12345678, "wr_w8");
      txn(0, 1'b0, 32'h0000_0020, 32'h0, "rd_w8_new");
      txn(0, 1'b1, 32'h0004_0000, 32'hFFFF_FFFF, "oor_wr");
      txn(1, 1'b0, 32'h0000_0023, 32'h0, "rd_lowbits");

      // Arbitration and back-to-back
      contend(1'b1, 1'b1, 4, "tie");
      contend(1'b1, 1'b0, 4, "b2b_req0");
      contend(1'b0, 1'b1, 3, "b2b_req1");

      // Reset during CAPTURE of a write
      drive(0, 1'b1, 1'b1, 32'h0000_0030, 32'hCAFEF00D);
      #1;
      chk1("rstmid/ready", req0_ready, 1'b1);
      tick;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk1("rstmid/web", ram_web, 1'b1);
      tick;
      rst_n = 1'b0;
      #1;
      chk1("rstmid/rsp0", rsp0_valid, 1'b0);
      chk("rstmid/rdata0", rsp0_rdata, 32'h0);
      chk("rstmid/rdata1", rsp1_rdata, 32'h0);
      chk("rstmid/addrb", ram_addrb, 32'h0);
      chk("rstmid/dinb", ram_dinb, 32'h0);
      chk1("rstmid/web0", ram_web, 1'b0);
      chk1("rstmid/busy", busy, 1'b0);
      exp_mem[12] = 32'hCAFEF00D;
      model_last  = 1'b1;
      last_rd[0]  = '0;  last_rd[1]  = '0;
      last_err[0] = 1'b0; last_err[1] = 1'b0;
      tick;
      rst_n = 1'b1;
      tick;
      chk1("rstmid/no_rsp0", rsp0_valid, 1'b0);
      chk1("rstmid/no_rsp1", rsp1_valid, 1'b0);
      tick;
      chk1("rstmid/no_rsp0b", rsp0_valid, 1'b0);
      chk_hold("rstmid");
      txn(1, 1'b0, 32'h0000_0030, 32'h0, "post_rst_rd");

      // Randomized isolated accesses with idle gaps
      for (int n = 0; n < 40; n++) begin
         txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             rand_addr(), $urandom(), "rand");
         repeat ($urandom_range(0, 2)) tick;
      end

      // Randomized contention bursts
      for (int n = 0; n < 4; n++) begin
         contend(1'b1, 1'b1, int'($urandom_range(2, 5)), "rand_tie");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
